// File: rtl/map_writer.sv
// map_writer: loads, holds and clears the 15x10 tile map (4 bits per tile).
// Define MAP_WRITER_BORDER_EN to force every border tile to WALL during load.
module map_writer #(
  parameter int COLS   = 15,
  parameter int ROWS   = 10,
  parameter int TILE_W = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_start,
  input  logic [3:0]                    tile_data,
  input  logic                          tile_valid,
  output logic                          tile_ready,
  input  logic                          clr_req,
  input  logic [7:0]                    clr_idx,
  output logic                          clr_ack,
  output logic [COLS*ROWS*TILE_W-1:0]   map,
  output logic                          map_valid,
  output logic                          busy,
  output logic [7:0]                    tile_idx,
  output logic [7:0]                    pickups_left,
  output logic                          level_done,
  output logic                          error
);

  localparam int N = COLS * ROWS;
  localparam logic [7:0] NIDX = 8'(N);
  localparam logic [7:0] LAST = 8'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_READY
  } state_t;

  state_t state;

  logic [3:0] wr_code;
  logic       wr_pick;
  logic       wr_err;
  logic [7:0] clr_sel;
  logic [3:0] cur_code;
  logic       clr_hit;

`ifdef MAP_WRITER_BORDER_EN
  logic [3:0] col_q;
  logic [3:0] row_q;
  logic       on_border;

  assign on_border = (row_q == 4'd0) || (row_q == 4'(ROWS - 1)) ||
                     (col_q == 4'd0) || (col_q == 4'(COLS - 1));
`endif

  assign tile_ready = (state == S_LOAD);
  assign busy       = (state == S_CLEAR) || (state == S_LOAD);
  assign level_done = map_valid && (pickups_left == 8'd0);

  // Out-of-range clear indices are steered to tile 0 and then rejected.
  assign clr_sel  = (clr_idx < NIDX) ? clr_idx : 8'd0;
  assign cur_code = map[int'(clr_sel)*TILE_W +: TILE_W];
  assign clr_hit  = (clr_idx < NIDX) && (cur_code[3:1] == 3'b001);

  // Decide what an incoming tile becomes once stored.
  always_comb begin
    wr_code = 4'd0;
    wr_pick = 1'b0;
    wr_err  = 1'b0;
    if (tile_data[3:2] != 2'b00) begin
      wr_err = 1'b1;
    end else begin
      wr_code = tile_data;
      wr_pick = tile_data[1];
    end
`ifdef MAP_WRITER_BORDER_EN
    if (on_border) begin
      wr_code = 4'd1;
      wr_pick = 1'b0;
      wr_err  = 1'b0;
    end
`endif
  end

  // Level FSM together with the map, counters and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      map          <= '0;
      map_valid    <= 1'b0;
      tile_idx     <= 8'd0;
      pickups_left <= 8'd0;
      error        <= 1'b0;
      clr_ack      <= 1'b0;
`ifdef MAP_WRITER_BORDER_EN
      col_q        <= 4'd0;
      row_q        <= 4'd0;
`endif
    end else begin
      clr_ack <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (load_start) state <= S_CLEAR;
        end
        S_CLEAR: begin
          map          <= '0;
          map_valid    <= 1'b0;
          tile_idx     <= 8'd0;
          pickups_left <= 8'd0;
          error        <= 1'b0;
`ifdef MAP_WRITER_BORDER_EN
          col_q        <= 4'd0;
          row_q        <= 4'd0;
`endif
          state        <= S_LOAD;
        end
        S_LOAD: begin
          if (load_start) begin
            state <= S_CLEAR;
          end else if (tile_valid) begin
            map[int'(tile_idx)*TILE_W +: TILE_W] <= wr_code;
            if (wr_pick) pickups_left <= pickups_left + 8'd1;
            if (wr_err) error <= 1'b1;
            if (tile_idx == LAST) begin
              tile_idx  <= 8'd0;
              map_valid <= 1'b1;
              state     <= S_READY;
            end else begin
              tile_idx <= tile_idx + 8'd1;
            end
`ifdef MAP_WRITER_BORDER_EN
            if (tile_idx == LAST) begin
              col_q <= 4'd0;
              row_q <= 4'd0;
            end else if (col_q == 4'(COLS - 1)) begin
              col_q <= 4'd0;
              row_q <= row_q + 4'd1;
            end else begin
              col_q <= col_q + 4'd1;
            end
`endif
          end
        end
        S_READY: begin
          if (load_start) begin
            state <= S_CLEAR;
          end else if (clr_req && clr_hit) begin
            map[int'(clr_sel)*TILE_W +: TILE_W] <= '0;
            if (pickups_left != 8'd0) pickups_left <= pickups_left - 8'd1;
            clr_ack <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
